// File: rtl/counter_gen.sv
// Parametrised LED / trigger counter with prescaler, up/down, load and one-shot.
// Optional compare trigger output enabled by defining COUNTER_GEN_TRIG_EN.
module counter_gen #(
    parameter int unsigned     CNT_W  = 32,
    parameter int unsigned     LED_N  = 4,
    parameter int unsigned     PRE_W  = 8,
    parameter longint unsigned MODULO = 0
) (
    input  logic             clk1,
    input  logic             rstn,
    input  logic             en,
    input  logic             dir,
    input  logic             oneshot,
    input  logic [PRE_W-1:0] pre_div,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
`ifdef COUNTER_GEN_TRIG_EN
    input  logic [CNT_W-1:0] cmp_val,
    output logic             trig,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic [LED_N-1:0] led,
    output logic             tc,
    output logic             done
);

    localparam logic [CNT_W-1:0] TOP = (MODULO == 64'd0) ? {CNT_W{1'b1}}
                                                         : CNT_W'(MODULO - 64'd1);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [0:0]       state_q, state_d;
    logic             tc_q, tc_d;
    logic             tick;
    logic             at_term;

    always_comb begin
        cnt_d     = cnt_q;
        pre_cnt_d = pre_cnt_q;
        state_d   = state_q;
        tc_d      = 1'b0;
        tick      = en && (pre_cnt_q >= pre_div) && (state_q == ST_RUN);
        at_term   = dir ? (cnt_q == TOP) : (cnt_q == '0);

        // Load wins over a coincident tick; that tick is simply dropped.
        if (load) begin
            cnt_d     = (load_val > TOP) ? TOP : load_val;
            pre_cnt_d = '0;
            state_d   = ST_RUN;
        end else if (tick) begin
            pre_cnt_d = '0;
            tc_d      = at_term;
            if (at_term && oneshot) begin
                state_d = ST_DONE;
            end else if (dir) begin
                cnt_d = at_term ? '0 : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = at_term ? TOP : cnt_q - CNT_W'(1);
            end
        end else if (en && (state_q == ST_RUN)) begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk1) begin
        if (!rstn) begin
            cnt_q     <= '0;
            pre_cnt_q <= '0;
            state_q   <= ST_RUN;
            tc_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pre_cnt_q <= pre_cnt_d;
            state_q   <= state_d;
            tc_q      <= tc_d;
        end
    end

`ifdef COUNTER_GEN_TRIG_EN
    logic trig_q, trig_d;

    // Fires only when a tick actually moves cnt onto cmp_val, never on load or terminal hold.
    always_comb begin
        trig_d = !load && tick && !(at_term && oneshot) && (cnt_d == cmp_val);
    end

    always_ff @(posedge clk1) begin
        if (!rstn) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_d;
        end
    end

    assign trig = trig_q;
`endif

    assign cnt  = cnt_q;
    assign led  = cnt_q[CNT_W-1 -: LED_N];
    assign tc   = tc_q;
    assign done = (state_q == ST_DONE);

endmodule

// File: doc/counter_gen.md
Name: counter_gen

Overview:
- Parametrised successor to the free-running LED counter.
- Adds width, modulo and LED-tap generalisation, a programmable prescaler, count enable, up/down direction, synchronous load, and one-shot mode.
- Adds a terminal-count pulse usable as a debugger trigger source.
- Sits between the platform clock (internal oscillator) and board LEDs / trigger logic.

Parameters:
- CNT_W, 32, counter width; legal range 8..64.
- LED_N, 4, number of LED outputs, tapped from the counter MSBs; legal range 1..CNT_W.
- PRE_W, 8, prescaler width.
- MODULO, 0. 0 gives natural 2^CNT_W wrap. Nonzero gives a count range of 0..MODULO-1. Must be < 2^CNT_W.

Ports:
- clk1  in  1  platform clock; all logic on its rising edge.
- rstn  in  1  reset, synchronous, active-low.
- en  in  1  count enable; prescaler and counter hold when 0.
- dir  in  1  1 = up, 0 = down; sampled on each tick.
- oneshot  in  1  1 = stop at terminal instead of wrapping.
- pre_div  in  PRE_W  one tick every pre_div+1 enabled clocks.
- load  in  1  synchronous load strobe.
- load_val  in  CNT_W  load value.
- cnt  out  CNT_W  registered count.
- led  out  LED_N  equals cnt[CNT_W-1 -: LED_N].
- tc  out  1  one-cycle terminal-count pulse.
- done  out  1  one-shot finished (level).

Behaviour:
- **Reset.** rstn=0 at a clk1 edge sets: cnt=0, led=0, pre_cnt=0, tc=0, done=0, state=RUN. Reset dominates all other inputs, including mid-count and in DONE.
- **TOP.** TOP = all-ones if MODULO==0, else MODULO-1.
- **Prescaler.**
  - tick = en && (pre_cnt >= pre_div) && state==RUN.
  - On tick, pre_cnt returns to 0; on other enabled cycles it increments; when en=0 it holds.
  - The >= compare means lowering pre_div mid-period ticks on the next enabled cycle, with no runaway.
  - pre_div=0 ticks every enabled cycle.
- **Latency.** cnt, tc and done update on the same clk1 edge that samples tick: 1 cycle.
- **Up count.** cnt==TOP ? 0 : cnt+1. Wrap asserts tc.
- **Down count.** cnt==0 ? TOP : cnt-1. Wrap asserts tc.
- **One-shot.** When oneshot=1 and a tick would wrap:
  - cnt holds at its terminal value (TOP when up, 0 when down);
  - tc pulses once; done=1; state goes to DONE.
- **FSM.** Two states.
  - RUN -> DONE on a one-shot terminal tick.
  - DONE -> RUN only on load (or reset).
  - In DONE: no ticks, tc=0, cnt holds, prescaler holds at 0. Deasserting oneshot does not leave DONE.
- **Load.**
  - load=1: cnt=min(load_val, TOP), pre_cnt=0, done=0, state=RUN, tc=0.
  - Load has priority over a coincident tick; that tick is discarded.
- **tc.** Registered; high for exactly one cycle per wrap or terminal event; never asserted on load or reset.
- **dir.** A change of dir between ticks takes effect on the next tick. No glitch or skip at the turnaround.
- **Arithmetic.** Unsigned and modulo CNT_W; there is no out-of-range state (load is clamped).

Optional Feature:
- Macro COUNTER_GEN_TRIG_EN.
- **Defined:**
  - Adds input cmp_val [CNT_W] and output trig [1].
  - trig is a registered one-cycle pulse on any tick that updates cnt to equal cmp_val. Loads do not fire trig.
  - trig resets to 0. It is a Reveal trigger source.
- **Undefined:** cmp_val and trig are absent; no compare logic is synthesised.

Test Plan:
- Reset: run 100 cycles, then rstn=0 for 1 edge -> next cycle cnt=0, led=0, tc=0, done=0; resumes counting from 0 once rstn=1.
- Prescale/up, CNT_W=8, MODULO=0, pre_div=3, en=1, dir=1 -> cnt increments every 4 cycles; 255->0 asserts tc for exactly 1 cycle; led tracks cnt[7:4].
- Modulo/down, MODULO=10, pre_div=0, dir=0, load_val=2 -> sequence 2,1,0,9,8; tc only on the 0->9 edge.
- One-shot, oneshot=1, dir=1, MODULO=5, load 3 -> 3,4 then hold 4, tc once, done=1. en toggling has no effect; load 0 -> done=0 and counting restarts.
- Load/tick collision: load=1 with load_val=7 on a tick cycle where cnt=TOP -> cnt=7, tc=0. Clamp case: MODULO=10, load_val=200 -> cnt=9.
- With COUNTER_GEN_TRIG_EN, cmp_val=0x40, pre_div=1 -> trig 1-cycle pulse on the edge where cnt becomes 0x40; no trig when 0x40 is loaded directly.
